// File: rtl/tdm_demux8.sv
// Receive side of an 8-slot TDM serial link: slot tracking, deserialisation, lock and sync-error reporting.
// Frame word appears on the same edge as the slot-7 bit; en=0 freezes everything except the one-cycle pulses.
module tdm_demux8 #(
   parameter int SYNC_LOSS = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic       din,
   input  logic       sync,
   output logic [7:0] q,
   output logic       frame_valid,
   output logic       locked,
   output logic       sync_err,
   output logic [2:0] slot
);

   localparam int MW = $clog2(SYNC_LOSS + 1);
   localparam logic [MW:0] LOSS = SYNC_LOSS[MW:0];

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t        state;
   logic [7:0]    shadow;
   logic [MW-1:0] miss_cnt;
   logic [MW:0]   miss_next;

   assign miss_next = {1'b0, miss_cnt} + {{MW{1'b0}}, 1'b1};
   assign locked    = (state == LOCKED);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= HUNT;
         slot        <= 3'd0;
         shadow      <= 8'h00;
         q           <= 8'h00;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         miss_cnt    <= '0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (en) begin
            case (state)
               HUNT: begin
                  if (sync) begin
                     shadow[0] <= din;
                     slot      <= 3'd1;
                     miss_cnt  <= '0;
                     state     <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (slot == 3'd0) begin
                     if (sync) begin
                        shadow[0] <= din;
                        slot      <= 3'd1;
                        miss_cnt  <= '0;
                     end else begin
                        sync_err <= 1'b1;
                        // Flywheel through isolated missing markers; give up after SYNC_LOSS in a row.
                        if (miss_next < LOSS) begin
                           shadow[0] <= din;
                           slot      <= 3'd1;
                           miss_cnt  <= miss_next[MW-1:0];
                        end else begin
                           state    <= HUNT;
                           slot     <= 3'd0;
                           shadow   <= 8'h00;
                           miss_cnt <= '0;
                        end
                     end
                  end else if (sync) begin
                     // Misplaced marker: drop the partial frame and restart at slot 0.
                     sync_err <= 1'b1;
                     shadow   <= {7'b0, din};
                     slot     <= 3'd1;
                     miss_cnt <= '0;
                  end else begin
                     shadow[slot] <= din;
                     slot         <= slot + 3'd1;
                     if (slot == 3'd7) begin
                        q           <= {din, shadow[6:0]};
                        frame_valid <= 1'b1;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux8.sv
// Self-checking bench for tdm_demux8: vector table, hand sequences for corner cases, random run vs. model.
module tb_tdm_demux8;

   localparam int SYNC_LOSS = 2;

   logic       clk, rstn, en, din, sync;
   logic [7:0] q;
   logic       frame_valid, locked, sync_err;
   logic [2:0] slot;

   tdm_demux8 #(.SYNC_LOSS(SYNC_LOSS)) dut (
      .clk(clk), .rstn(rstn), .en(en), .din(din), .sync(sync),
      .q(q), .frame_valid(frame_valid), .locked(locked),
      .sync_err(sync_err), .slot(slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       en, din, sync;
      logic [7:0] q;
      logic       fv, lk, err;
      logic [2:0] slot;
   } vec_t;
   vec_t vecs[$];

   function automatic void v(input logic e, d, s, input logic [7:0] eq,
                             input logic efv, elk, eerr, input logic [2:0] es);
      vec_t t;
      t.en = e; t.din = d; t.sync = s; t.q = eq;
      t.fv = efv; t.lk = elk; t.err = eerr; t.slot = es;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eq, input logic efv, elk, eerr,
                          input logic [2:0] es);
      chk({tag, ".q"}, q, eq);
      chk({tag, ".frame_valid"}, {7'b0, frame_valid}, {7'b0, efv});
      chk({tag, ".locked"}, {7'b0, locked}, {7'b0, elk});
      chk({tag, ".sync_err"}, {7'b0, sync_err}, {7'b0, eerr});
      chk({tag, ".slot"}, {5'b0, slot}, {5'b0, es});
   endtask

   task automatic step(input logic e, d, s);
      en = e; din = d; sync = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      en = 1'b0; din = 1'b0; sync = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] f);
      for (int i = 0; i < 8; i++) step(1'b1, f[i], i == 0);
   endtask

   // Reference model: slot position as an integer, frame bits collected in an array.
   bit         m_lock;
   int         m_pos, m_miss;
   bit [7:0]   m_bits;
   logic [7:0] m_q;
   bit         m_fv, m_err;

   task automatic model_reset();
      m_lock = 0; m_pos = 0; m_miss = 0; m_bits = '0; m_q = 8'h00; m_fv = 0; m_err = 0;
   endtask

   task automatic model_step(input bit e, d, s);
      m_fv = 0; m_err = 0;
      if (!e) return;
      if (!m_lock) begin
         if (s) begin
            m_bits = '0; m_bits[0] = d; m_pos = 1; m_miss = 0; m_lock = 1;
         end
      end else if (s) begin
         if (m_pos != 0) m_err = 1;
         m_bits = '0; m_bits[0] = d; m_pos = 1; m_miss = 0;
      end else if (m_pos == 0) begin
         m_err = 1;
         m_miss++;
         if (m_miss >= SYNC_LOSS) begin
            m_lock = 0; m_pos = 0; m_miss = 0; m_bits = '0;
         end else begin
            m_bits[0] = d; m_pos = 1;
         end
      end else begin
         m_bits[m_pos] = d;
         if (m_pos == 7) begin
            m_q = m_bits; m_fv = 1;
         end
         m_pos = (m_pos + 1) % 8;
      end
   endtask

   initial begin
      int         strobes, fv_cnt;
      logic [7:0] fr;
      logic       e, d, s;

      rstn = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0;
      #2;
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Lock + capture of 4D, misplaced sync at slot 3, en=0 hold, sync on slot 7.
      v(1, 1, 0, 8'h00, 0, 0, 0, 3'd0);
      v(1, 1, 1, 8'h00, 0, 1, 0, 3'd1);
      v(1, 0, 0, 8'h00, 0, 1, 0, 3'd2);
      v(1, 1, 0, 8'h00, 0, 1, 0, 3'd3);
      v(1, 1, 0, 8'h00, 0, 1, 0, 3'd4);
      v(1, 0, 0, 8'h00, 0, 1, 0, 3'd5);
      v(1, 0, 0, 8'h00, 0, 1, 0, 3'd6);
      v(1, 1, 0, 8'h00, 0, 1, 0, 3'd7);
      v(1, 0, 0, 8'h4D, 1, 1, 0, 3'd0);
      v(1, 1, 1, 8'h4D, 0, 1, 0, 3'd1);
      v(1, 0, 0, 8'h4D, 0, 1, 0, 3'd2);
      v(1, 0, 0, 8'h4D, 0, 1, 0, 3'd3);
      v(1, 0, 1, 8'h4D, 0, 1, 1, 3'd1);
      for (int k = 2; k <= 7; k++) v(1, 1, 0, 8'h4D, 0, 1, 0, 3'(k));
      v(1, 1, 0, 8'hFE, 1, 1, 0, 3'd0);
      v(0, 1, 1, 8'hFE, 0, 1, 0, 3'd0);
      v(1, 0, 1, 8'hFE, 0, 1, 0, 3'd1);
      for (int k = 2; k <= 7; k++) v(1, 1, 0, 8'hFE, 0, 1, 0, 3'(k));
      v(1, 1, 1, 8'hFE, 0, 1, 1, 3'd1);
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].din, vecs[i].sync);
         chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].fv, vecs[i].lk, vecs[i].err,
                 vecs[i].slot);
      end

      // Strobe gaps: en every other cycle, junk on din/sync in the gaps.
      do_reset();
      fr = 8'h4D; strobes = 0; fv_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            step(1'b1, fr[i/2], i == 0);
            strobes++;
         end else begin
            step(1'b0, 1'($urandom), 1'b1);
         end
         if (frame_valid) fv_cnt++;
         chk($sformatf("gap%0d.slot", i), {5'b0, slot}, 8'(strobes % 8));
      end
      chk("gap.q", q, 8'h4D);
      chk("gap.fv_count", 8'(fv_cnt), 8'd1);

      // Sync loss: first miss flywheels, second consecutive miss drops to HUNT.
      do_reset();
      send_frame(8'h4D);
      step(1, 1, 0);
      chk_all("miss1", 8'h4D, 1'b0, 1'b1, 1'b1, 3'd1);
      fr = 8'h1F;
      for (int i = 1; i < 8; i++) step(1'b1, fr[i], 1'b0);
      chk_all("miss1.frame", 8'h1F, 1'b1, 1'b1, 1'b0, 3'd0);
      step(1, 0, 0);
      chk_all("miss2", 8'h1F, 1'b0, 1'b0, 1'b1, 3'd0);
      step(1, 1, 0);
      chk_all("miss2.hunt", 8'h1F, 1'b0, 1'b0, 1'b0, 3'd0);

      // Mid-frame asynchronous reset, then bits without sync are ignored.
      do_reset();
      send_frame(8'hA5);
      fr = 8'h3C;
      for (int i = 0; i < 5; i++) step(1'b1, fr[i], i == 0);
      chk_all("pre_rst", 8'hA5, 1'b0, 1'b1, 1'b0, 3'd5);
      #2;
      rstn = 1'b0;
      #1;
      chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      chk_all("post_rst.hunt", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
      step(1, 1, 1);
      chk_all("post_rst.lock", 8'h00, 1'b0, 1'b1, 1'b0, 3'd1);

      // Random stream against the model.
      do_reset();
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         e = ($urandom % 4) != 0;
         d = 1'($urandom);
         if (m_pos == 0) s = ($urandom % 10) != 0;
         else            s = ($urandom % 16) == 0;
         model_step(e, d, s);
         step(e, d, s);
         chk_all("rand", m_q, m_fv, m_lock, m_err, 3'(m_pos));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
